// File: rtl/pif_xbus_arb_pkg.sv
// Shared definitions for the XI/XO register-bus sequencer: bus geometry,
// the read pipeline depth of the register chain and the FSM encoding.
package pif_xbus_arb_pkg;

  localparam int XA_BITS       = 3;
  localparam int XSUBA_MAX     = 3;
  localparam int I2C_TYPE_BITS = 2;
  localparam int XO_RD_LAT     = 5;

  typedef enum logic [1:0] {
    XBUS_ST_IDLE = 2'd0,
    XBUS_ST_WR   = 2'd1,
    XBUS_ST_RD   = 2'd2,
    XBUS_ST_DONE = 2'd3
  } xbus_state_e;

  // Bits needed to hold an index in 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pif_rr_arb.sv
// Combinational round-robin pick: the first set request strictly after
// rr_last (wrapping) wins. Returns the winner one-hot and as an index.
module pif_rr_arb
  import pif_xbus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  // Scan from the farthest to the nearest position so the nearest set request overwrites the rest.
  always_comb begin
    int pos;
    pos       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int off = NREQ; off >= 1; off--) begin
      pos = (int'(rr_last) + off) % NREQ;
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        grant_idx  = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/pif_xbus_arb.sv
// Round-robin sequencer for the XI/XO register bus. Grants one requester at a
// time, drives the XI strobes, waits out the registered XO read chain and
// returns the read byte. Owns the auto-incrementing read sub-address, which
// restarts whenever a read targets a different address or a write intervenes.
module pif_xbus_arb
  import pif_xbus_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int RD_LAT = XO_RD_LAT,
  parameter int AW     = XA_BITS,
  parameter int DW     = 8 - I2C_TYPE_BITS
) (
  input  logic                   xclk,
  input  logic                   xrst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [7:0]             rd_data,
  output logic                   busy,
  output logic                   XI_PWr,
  output logic [2**XA_BITS-1:0]  XI_PRWA,
  output logic                   XI_PRdFinished,
  output logic [XSUBA_MAX:0]     XI_PRdSubA,
  output logic [DW-1:0]          XI_PD,
  input  logic [7:0]             XO
);

  localparam int PW = 2**XA_BITS;
  localparam int SW = XSUBA_MAX + 1;
  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(RD_LAT);

  xbus_state_e     state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [AW-1:0]   last_rd_addr_q, last_rd_addr_d;
  logic            last_rd_vld_q, last_rd_vld_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            pwr_q, pwr_d;
  logic            fin_q, fin_d;
  logic [PW-1:0]   prwa_q, prwa_d;
  logic [DW-1:0]   pd_q, pd_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            rd_last;

  pif_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req       (req),
    .rr_last   (rr_last_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign arb_vld   = |arb_grant;
  assign sel_wr    = req_wr[arb_idx];
  assign sel_addr  = req_addr[int'(arb_idx)*AW +: AW];
  assign sel_wdata = req_wdata[int'(arb_idx)*DW +: DW];
  assign rd_last   = (cnt_q == CW'(RD_LAT - 1));

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge xclk or negedge xrst_n) begin
    if (!xrst_n) state_q <= XBUS_ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: grant from IDLE, one WR cycle, RD_LAT RD cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      XBUS_ST_IDLE: if (arb_vld) state_d = sel_wr ? XBUS_ST_WR : XBUS_ST_RD;
      XBUS_ST_WR:   state_d = XBUS_ST_DONE;
      XBUS_ST_RD:   if (rd_last) state_d = XBUS_ST_DONE;
      XBUS_ST_DONE: state_d = XBUS_ST_IDLE;
      default:      state_d = XBUS_ST_IDLE;
    endcase
  end

  // Next values of the latched transaction, sub-address tracking and registered bus outputs.
  always_comb begin
    grant_d        = grant_q;
    rr_last_d      = rr_last_q;
    cnt_d          = cnt_q;
    sub_d          = sub_q;
    last_rd_addr_d = last_rd_addr_q;
    last_rd_vld_d  = last_rd_vld_q;
    rd_data_d      = rd_data_q;
    prwa_d         = prwa_q;
    pd_d           = pd_q;
    ack_d          = '0;
    pwr_d          = 1'b0;
    fin_d          = 1'b0;
    busy_d         = (state_d != XBUS_ST_IDLE);
    case (state_q)
      XBUS_ST_IDLE: begin
        if (arb_vld) begin
          grant_d   = arb_idx;
          rr_last_d = arb_idx;
          prwa_d    = PW'(sel_addr);
          pd_d      = sel_wdata;
          cnt_d     = '0;
          if (sel_wr) begin
            pwr_d = 1'b1;
          end else if (!last_rd_vld_q || (sel_addr != last_rd_addr_q)) begin
            sub_d = '0;
          end
        end
      end
      XBUS_ST_WR: begin
        sub_d         = '0;
        last_rd_vld_d = 1'b0;
        ack_d         = NREQ'(1) << grant_q;
      end
      XBUS_ST_RD: begin
        if (rd_last) begin
          rd_data_d      = XO;
          fin_d          = 1'b1;
          ack_d          = NREQ'(1) << grant_q;
          sub_d          = (sub_q == SW'(XSUBA_MAX)) ? '0 : sub_q + SW'(1);
          last_rd_addr_d = prwa_q[AW-1:0];
          last_rd_vld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge xclk or negedge xrst_n) begin
    if (!xrst_n) begin
      grant_q        <= '0;
      rr_last_q      <= IW'(NREQ - 1);
      cnt_q          <= '0;
      sub_q          <= '0;
      last_rd_addr_q <= '0;
      last_rd_vld_q  <= 1'b0;
      rd_data_q      <= '0;
      ack_q          <= '0;
      busy_q         <= 1'b0;
      pwr_q          <= 1'b0;
      fin_q          <= 1'b0;
      prwa_q         <= '0;
      pd_q           <= '0;
    end else begin
      grant_q        <= grant_d;
      rr_last_q      <= rr_last_d;
      cnt_q          <= cnt_d;
      sub_q          <= sub_d;
      last_rd_addr_q <= last_rd_addr_d;
      last_rd_vld_q  <= last_rd_vld_d;
      rd_data_q      <= rd_data_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      pwr_q          <= pwr_d;
      fin_q          <= fin_d;
      prwa_q         <= prwa_d;
      pd_q           <= pd_d;
    end
  end

  assign ack            = ack_q;
  assign rd_data        = rd_data_q;
  assign busy           = busy_q;
  assign XI_PWr         = pwr_q;
  assign XI_PRWA        = prwa_q;
  assign XI_PRdFinished = fin_q;
  assign XI_PRdSubA     = sub_q;
  assign XI_PD          = pd_q;

endmodule
